reloj_contador: RTL



---
 rtl/reloj_contador.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/reloj_contador.sv
// RELOJ time-of-day core: BCD HH:MM:SS from a prescaled 1 s tick,
// two debounced set buttons, registered 7-seg digits, colon and blink.
//
// Ports:
//   Clock, Reset        : system clock, async active-high reset
//   btn_mode, btn_inc   : raw active-high push-buttons (asynchronous)
//   display0..display3  : min units, min tens, hour units, hour tens
//                         as active-low {g,f,e,d,c,b,a}
//   colon               : high during first half of each second
//   mode_state          : 00 RUN, 01 SET_HOUR, 10 SET_MIN
module reloj_contador #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] display0,
  output logic [6:0] display1,
  output logic [6:0] display2,
  output logic [6:0] display3,
  output logic       colon,
  output logic [1:0] mode_state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t state, state_nx;

  // Button path: index 0 = mode, 1 = inc
  logic [1:0]    raw, s1, s2, lvl, arm, press;
  logic [1:0]    vld;
  logic [DW-1:0] cnt [2];

  assign raw = {btn_inc, btn_mode};

  // vld marks when s2 holds a real sample rather than reset fill
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1  <= '0;
      s2  <= '0;
      vld <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      vld <= {vld[0], 1'b1};
    end
  end

  // A button held through reset must be seen low once (arm) before
  // its debounced rise may count as a press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      lvl    <= '0;
      arm    <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (vld[1] && !s2[i]) arm[i] <= 1'b1;
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i]   <= '0;
          lvl[i]   <= s2[i];
          press[i] <= s2[i] & arm[i];
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  logic mode_p, inc_p;
  assign mode_p = press[0];
  assign inc_p  = press[1] & ~press[0];

  // Prescaler
  logic [PW-1:0] presc;
  logic          tick, half, sec_clr;

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign half    = (presc < PW'(TICK_DIV / 2));
  assign sec_clr = (state == SET_MIN) && mode_p;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc <= '0;
    end else if (sec_clr || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // FSM
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mode_p) begin
      unique case (state)
        RUN:      state_nx = SET_HOUR;
        SET_HOUR: state_nx = SET_MIN;
        SET_MIN:  state_nx = RUN;
        default:  state_nx = RUN;
      endcase
    end
  end

  // BCD time
  logic [3:0] s_u, m_u, h_u;
  logic [2:0] s_t, m_t;
  logic [1:0] h_t;
  logic       run_tick, s_wrap, m_wrap, h_wrap;
  logic       step_m, step_h;

  assign run_tick = (state == RUN) && tick;
  assign s_wrap   = (s_u == 4'd9) && (s_t == 3'd5);
  assign m_wrap   = (m_u == 4'd9) && (m_t == 3'd5);
  assign h_wrap   = (h_u == 4'd3) && (h_t == 2'd2);
  assign step_m   = (run_tick && s_wrap) ||
                    ((state == SET_MIN) && inc_p);
  assign step_h   = (run_tick && s_wrap && m_wrap) ||
                    ((state == SET_HOUR) && inc_p);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s_u <= '0;
      s_t <= '0;
      m_u <= '0;
      m_t <= '0;
      h_u <= '0;
      h_t <= '0;
    end else begin
      if (sec_clr) begin
        s_u <= '0;
        s_t <= '0;
      end else if (run_tick) begin
        if (s_u == 4'd9) begin
          s_u <= '0;
          s_t <= (s_t == 3'd5) ? 3'd0 : s_t + 3'd1;
        end else begin
          s_u <= s_u + 4'd1;
        end
      end
      if (step_m) begin
        if (m_u == 4'd9) begin
          m_u <= '0;
          m_t <= (m_t == 3'd5) ? 3'd0 : m_t + 3'd1;
        end else begin
          m_u <= m_u + 4'd1;
        end
      end
      if (step_h) begin
        if (h_wrap) begin
          h_u <= '0;
          h_t <= '0;
        end else if (h_u == 4'd9) begin
          h_u <= '0;
          h_t <= h_t + 2'd1;
        end else begin
          h_u <= h_u + 4'd1;
        end
      end
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  logic blank_h, blank_m;
  assign blank_h = (state == SET_HOUR) && !half;
  assign blank_m = (state == SET_MIN) && !half;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      display0   <= ZERO;
      display1   <= ZERO;
      display2   <= ZERO;
      display3   <= ZERO;
      colon      <= 1'b0;
      mode_state <= 2'b00;
    end else begin
      display0   <= blank_m ? BLANK : seg(m_u);
      display1   <= blank_m ? BLANK : seg({1'b0, m_t});
      display2   <= blank_h ? BLANK : seg(h_u);
      display3   <= blank_h ? BLANK : seg({2'b00, h_t});
      colon      <= half;
      mode_state <= state;
    end
  end

endmodule
